vga_timing_gen: RTL and testbench

//   Parametrised VGA raster timing generator; replaces separate horizontal/vertical counter blocks.

---
 rtl/vga_timing_gen.sv | 156 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. A horizontal counter (hcnt) and
//   a vertical counter (vcnt) step one pixel per pix_en pulse. Every output is
//   registered from the pre-increment counters on the same pix_en edge, so all
//   outputs stay mutually aligned, one clk behind the counter state.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   pix_en       in   pixel-advance enable, one clk wide
//   restart      in   synchronous re-align to (0,0); wins over pix_en
//   hsync        out  horizontal sync, level HS_POL while asserted
//   vsync        out  vertical sync, level VS_POL while asserted
//   de           out  1 while the displayed pixel is in the active area
//   x, y         out  displayed pixel column / row, blanking included
//   line_start   out  1-clk pulse when outputs first show hcnt == 0
//   frame_start  out  1-clk pulse when outputs first show (0,0)
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  input  logic             restart,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region boundaries kept 32 bits wide: a sync end may equal 2**CNT_W
  // when the back porch is zero, which would not fit in a cnt_t.
  localparam logic [31:0] H_ACT_END  = 32'(H_ACTIVE);
  localparam logic [31:0] H_SYNC_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] H_SYNC_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_ACT_END  = 32'(V_ACTIVE);
  localparam logic [31:0] V_SYNC_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] V_SYNC_END = 32'(V_ACTIVE + V_FP + V_SYNC);

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

  cnt_t hcnt_q, hcnt_d;
  cnt_t vcnt_q, vcnt_d;
  cnt_t x_q, x_d;
  cnt_t y_q, y_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic de_q, de_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // Region decode of the current (pre-increment) counter position.
  logic [31:0] h_ext, v_ext;
  logic        h_last, v_last;
  logic        in_h_active, in_v_active, in_h_sync, in_v_sync;

  assign h_ext       = 32'(hcnt_q);
  assign v_ext       = 32'(vcnt_q);
  assign h_last      = (hcnt_q == H_LAST);
  assign v_last      = (vcnt_q == V_LAST);
  assign in_h_active = (h_ext < H_ACT_END);
  assign in_v_active = (v_ext < V_ACT_END);
  assign in_h_sync   = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
  // vcnt only moves on an hcnt wrap, so vsync naturally spans whole lines.
  assign in_v_sync   = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    x_d           = x_q;
    y_d           = y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    // Pulses default low so they last exactly one clk whatever the divide ratio.
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (restart) begin
      // x/y deliberately hold; the next pix_en displays (0,0).
      hcnt_d  = '0;
      vcnt_d  = '0;
      de_d    = 1'b0;
      hsync_d = ~HS_POL;
      vsync_d = ~VS_POL;
    end else if (pix_en) begin
      hcnt_d = h_last ? '0 : hcnt_q + cnt_t'(1);
      if (h_last) begin
        vcnt_d = v_last ? '0 : vcnt_q + cnt_t'(1);
      end
      x_d           = hcnt_q;
      y_d           = vcnt_q;
      de_d          = in_h_active && in_v_active;
      hsync_d       = in_h_sync ? HS_POL : ~HS_POL;
      vsync_d       = in_v_sync ? VS_POL : ~VS_POL;
      line_start_d  = (hcnt_q == '0);
      frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: one instance with default 640x480 timing and
// one with a tiny 7x6 raster (active-high hsync). A pixel-index reference
// model predicts every output; feature tasks add targeted timing checks.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hfp, hsw, hbp;
    int va, vfp, vsw, vbp;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    int k;          // index of the next pixel to display, counted from (0,0)
    int x, y;
    bit de, hs, vs, ls, fs;
  } mstate_t;

  localparam cfg_t C0 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam cfg_t C1 = '{4, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pe0 = 1'b0, rs0 = 1'b0;
  logic pe1 = 1'b0, rs1 = 1'b0;

  logic       hs0, vs0, de0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       hs1, vs1, de1, ls1, fs1;
  logic [2:0] x1, y1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut0 (
    .clk(clk), .rst_n(rst_n), .pix_en(pe0), .restart(rs0),
    .hsync(hs0), .vsync(vs0), .de(de0), .x(x0), .y(y0),
    .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CNT_W(3)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pix_en(pe1), .restart(rs1),
    .hsync(hs1), .vsync(vs1), .de(de1), .x(x1), .y(y1),
    .line_start(ls1), .frame_start(fs1)
  );

  logic [24:0] obs0, obs1;
  assign obs0 = {x0, y0, de0, hs0, vs0, ls0, fs0};
  assign obs1 = {7'd0, x1, 7'd0, y1, de1, hs1, vs1, ls1, fs1};

  // ---------------- reference model ----------------
  function automatic mstate_t model_reset(cfg_t c);
    mstate_t s;
    s.k = 0; s.x = 0; s.y = 0;
    s.de = 1'b0; s.hs = ~c.hpol; s.vs = ~c.vpol; s.ls = 1'b0; s.fs = 1'b0;
    return s;
  endfunction

  function automatic mstate_t model_next(cfg_t c, mstate_t s, bit pe, bit rs);
    int ht, vt, px, py;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    s.ls = 1'b0;
    s.fs = 1'b0;
    if (rs) begin
      s.k = 0; s.de = 1'b0; s.hs = ~c.hpol; s.vs = ~c.vpol;
    end else if (pe) begin
      px = s.k % ht;
      py = (s.k / ht) % vt;
      s.x  = px;
      s.y  = py;
      s.de = (px < c.ha) && (py < c.va);
      s.hs = (px >= c.ha + c.hfp && px < c.ha + c.hfp + c.hsw) ? c.hpol : ~c.hpol;
      s.vs = (py >= c.va + c.vfp && py < c.va + c.vfp + c.vsw) ? c.vpol : ~c.vpol;
      s.ls = (px == 0);
      s.fs = (px == 0) && (py == 0);
      s.k  = (s.k + 1) % (ht * vt);
    end
    return s;
  endfunction

  function automatic logic [24:0] pack(mstate_t s);
    return {10'(s.x), 10'(s.y), s.de, s.hs, s.vs, s.ls, s.fs};
  endfunction

  mstate_t m0, m1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= model_reset(C0);
      m1 <= model_reset(C1);
    end else begin
      m0 <= model_next(C0, m0, pe0, rs0);
      m1 <= model_next(C1, m1, pe1, rs1);
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    #3 rst_n = 1'b0;
    #4;
    total++;
    if (obs0 !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_dut0 got=%h want=%h", obs0, {10'd0, 10'd0, 5'b01100});
    end
    total++;
    if (obs1 !== {20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_dut1 got=%h want=%h", obs1, {20'd0, 5'b00100});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (obs0 !== pack(m0)) begin
      bad++; $display("FAIL reset_hold got=%h want=%h", obs0, pack(m0));
    end
  endtask

  task automatic test_default_line();
    int cyc_ls, de_cnt, hs_run, hs_x;
    bit seen_ls, prev_hs;
    seen_ls = 0; de_cnt = 0; hs_run = 0; hs_x = 0; prev_hs = 1'b1; cyc_ls = 0;
    pe0 = 1'b1;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      total++;
      if (obs0 !== pack(m0)) begin
        bad++; $display("FAIL line_model cyc=%0d got=%h want=%h", cyc, obs0, pack(m0));
      end
      if (ls0) begin
        if (seen_ls) begin
          total++;
          if (cyc - cyc_ls != 800) begin
            bad++; $display("FAIL line_period got=%0d want=800", cyc - cyc_ls);
          end
          total++;
          if (de_cnt != 640) begin
            bad++; $display("FAIL de_per_line got=%0d want=640", de_cnt);
          end
        end
        seen_ls = 1; cyc_ls = cyc; de_cnt = 0;
      end
      if (de0) de_cnt++;
      if (!hs0 && prev_hs) begin
        hs_x = int'(x0); hs_run = 1;
      end else if (!hs0) begin
        hs_run++;
      end else if (!prev_hs) begin
        total++;
        if (hs_run != 96 || hs_x != 656) begin
          bad++; $display("FAIL hsync_pulse got=%0d@x%0d want=96@x656", hs_run, hs_x);
        end
      end
      prev_hs = hs0;
    end
    pe0 = 1'b0;
  endtask

  task automatic test_divided();
    int cyc_ls;
    bit seen_ls, prev_ls;
    seen_ls = 0; prev_ls = 0; cyc_ls = 0;
    @(negedge clk); rs0 = 1'b1; pe0 = 1'b0;
    @(negedge clk); rs0 = 1'b0; pe0 = 1'b1;
    for (int cyc = 0; cyc < 3400; cyc++) begin
      @(negedge clk);
      total++;
      if (obs0 !== pack(m0)) begin
        bad++; $display("FAIL div_model cyc=%0d got=%h want=%h", cyc, obs0, pack(m0));
      end
      if (ls0) begin
        total++;
        if (prev_ls || (fs0 && !ls0)) begin
          bad++; $display("FAIL div_pulse_width cyc=%0d got=2+ want=1", cyc);
        end
        if (seen_ls) begin
          total++;
          if (cyc - cyc_ls != 1600) begin
            bad++; $display("FAIL div_line_period got=%0d want=1600", cyc - cyc_ls);
          end
        end
        seen_ls = 1; cyc_ls = cyc;
      end
      prev_ls = ls0;
      pe0 = ~pe0;
    end
    pe0 = 1'b0;
  endtask

  // Run default raster until it displays (300,1); returns 0 on timeout.
  task automatic seek_300_1(output bit found);
    found = 0;
    pe0 = 1'b1;
    for (int cyc = 0; cyc < 3000 && !found; cyc++) begin
      @(negedge clk);
      if (x0 == 10'd300 && y0 == 10'd1) found = 1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL seek_timeout got=(%0d,%0d) want=(300,1)", x0, y0);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    @(negedge clk); rs0 = 1'b1;
    @(negedge clk); rs0 = 1'b0;
    seek_300_1(found);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs0 !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL midreset_async got=%h want=%h", obs0, {20'd0, 5'b01100});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (obs0 !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}) begin
      bad++; $display("FAIL midreset_first got=%h want=%h", obs0, {20'd0, 5'b11111});
    end
  endtask

  task automatic test_restart();
    bit found;
    seek_300_1(found);
    rs0 = 1'b1;
    @(negedge clk);
    rs0 = 1'b0;
    total++;
    if (obs0 !== {10'd300, 10'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL restart_state got=%h want=%h", obs0, {10'd300, 10'd1, 5'b01100});
    end
    @(negedge clk);
    total++;
    if (obs0 !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}) begin
      bad++; $display("FAIL restart_first got=%h want=%h", obs0, {20'd0, 5'b11111});
    end
    pe0 = 1'b0;
  endtask

  task automatic test_small_random();
    int fs_cnt, wraps, last_x;
    fs_cnt = 0; wraps = 0; last_x = -1;
    @(negedge clk); rs1 = 1'b1; pe1 = 1'b0;
    @(negedge clk); rs1 = 1'b0; pe1 = 1'b1;
    for (int cyc = 0; cyc < 3000 && fs_cnt < 4; cyc++) begin
      @(negedge clk);
      total++;
      if (obs1 !== pack(m1)) begin
        bad++; $display("FAIL small_model cyc=%0d got=%h want=%h", cyc, obs1, pack(m1));
      end
      if (pe1 && !rs1) begin
        total++;
        if (hs1 !== (x1 == 3'd5)) begin
          bad++; $display("FAIL small_hsync x=%0d got=%b want=%b", x1, hs1, x1 == 3'd5);
        end
        if (last_x == 6 && x1 == 3'd0) wraps++;
        last_x = int'(x1);
      end
      if (fs1) fs_cnt++;
      pe1 = 1'($urandom_range(0, 1));
    end
    total++;
    if (fs_cnt < 4) begin
      bad++; $display("FAIL small_frames got=%0d want=4", fs_cnt);
    end
    total++;
    if (wraps < 18) begin
      bad++; $display("FAIL small_wraps got=%0d want>=18", wraps);
    end
    // Random enables with occasional restarts.
    for (int cyc = 0; cyc < 1000; cyc++) begin
      pe1 = 1'($urandom_range(0, 1));
      rs1 = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      total++;
      if (obs1 !== pack(m1)) begin
        bad++; $display("FAIL small_restart cyc=%0d got=%h want=%h", cyc, obs1, pack(m1));
      end
    end
    pe1 = 1'b0; rs1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_line();
    test_divided();
    test_reset_mid();
    test_restart();
    test_small_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
